// File: rtl/ncc_seq_ctrl_if.sv
// Handshake and control bundle between the NCC sequencer and its
// descriptor/window sources and the PE array.
interface ncc_seq_ctrl_if #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int PIX_PER_WORD = 4,
    parameter int WIN_PIXELS   = 640
);
    logic                            start;
    logic                            abort;
    logic                            desc_valid;
    logic                            desc_ready;
    logic                            desc_load;
    logic [ROWS-1:0]                 desc_row_sel;
    logic [COLS/PIX_PER_WORD-1:0]    desc_col_grp;
    logic                            win_valid;
    logic                            win_ready;
    logic                            load_win_reg;
    logic                            load_acc_sum_reg;
    logic                            result_valid;
    logic [$clog2(WIN_PIXELS)-1:0]   result_idx;
    logic                            busy;
    logic                            done;

    modport master (
        output start, abort, desc_valid, win_valid,
        input  desc_ready, desc_load, desc_row_sel, desc_col_grp,
               win_ready, load_win_reg, load_acc_sum_reg,
               result_valid, result_idx, busy, done
    );

    modport slave (
        input  start, abort, desc_valid, win_valid,
        output desc_ready, desc_load, desc_row_sel, desc_col_grp,
               win_ready, load_win_reg, load_acc_sum_reg,
               result_valid, result_idx, busy, done
    );
endinterface

// File: rtl/ncc_seq_ctrl.sv
// Sequencer for the NCC PE array: loads one descriptor word-by-word into the
// array, then streams window pixels and flags valid row-accumulator results.
module ncc_seq_ctrl #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int PIX_PER_WORD = 4,
    parameter int WIN_PIXELS   = 640
) (
    input  logic                clk,
    input  logic                rst,
    ncc_seq_ctrl_if.slave       bus
);
    localparam int NGRP = COLS / PIX_PER_WORD;
    localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW   = $clog2(WIN_PIXELS);

    localparam logic [CW-1:0] COL_LAST      = CW'(NGRP - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);
    localparam logic [WW-1:0] WIN_LAST      = WW'(WIN_PIXELS - 1);
    localparam logic [WW-1:0] WIN_FIRST_RES = WW'(COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DESC_LOAD   = 2'd1,
        ST_WIN_STREAM  = 2'd2,
        ST_DONE        = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   col_c_r;
    logic [RW-1:0]   row_c_r;
    logic [WW-1:0]   win_c_r;
    logic            desc_acc_s;
    logic            win_acc_s;
    logic            result_valid_r;
    logic [WW-1:0]   result_idx_r;

    function automatic logic [ROWS-1:0] row_onehot(input logic [RW-1:0] idx);
        return ROWS'(1) << idx;
    endfunction

    function automatic logic [NGRP-1:0] grp_onehot(input logic [CW-1:0] idx);
        return NGRP'(1) << idx;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake/strobe decode; abort masks every strobe in its cycle.
    always_comb begin
        state_nxt_s           = state_r;
        desc_acc_s            = 1'b0;
        win_acc_s             = 1'b0;
        bus.desc_ready        = 1'b0;
        bus.desc_load         = 1'b0;
        bus.desc_row_sel      = '0;
        bus.desc_col_grp      = '0;
        bus.win_ready         = 1'b0;
        bus.load_win_reg      = 1'b0;
        bus.load_acc_sum_reg  = 1'b0;
        bus.done              = 1'b0;
        bus.busy              = (state_r != ST_IDLE);

        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt_s = ST_DESC_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DESC_LOAD: begin
                bus.desc_ready   = !bus.abort;
                bus.desc_row_sel = row_onehot(row_c_r);
                bus.desc_col_grp = grp_onehot(col_c_r);
                desc_acc_s       = bus.desc_valid && !bus.abort;
                bus.desc_load    = desc_acc_s;
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (desc_acc_s && (row_c_r == ROW_LAST) && (col_c_r == COL_LAST)) begin
                    state_nxt_s = ST_WIN_STREAM;
                end else begin
                    state_nxt_s = ST_DESC_LOAD;
                end
            end
            ST_WIN_STREAM: begin
                bus.win_ready        = !bus.abort;
                win_acc_s            = bus.win_valid && !bus.abort;
                bus.load_win_reg     = win_acc_s;
                bus.load_acc_sum_reg = win_acc_s;
                if (bus.abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (win_acc_s && (win_c_r == WIN_LAST)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WIN_STREAM;
                end
            end
            ST_DONE: begin
                bus.done    = !bus.abort;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Descriptor and window counters; column group wraps into the row counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_c_r <= '0;
            row_c_r <= '0;
            win_c_r <= '0;
        end else if (bus.abort || ((state_r == ST_IDLE) && bus.start)) begin
            col_c_r <= '0;
            row_c_r <= '0;
            win_c_r <= '0;
        end else begin
            if (desc_acc_s) begin
                if (col_c_r == COL_LAST) begin
                    col_c_r <= '0;
                    row_c_r <= (row_c_r == ROW_LAST) ? '0 : row_c_r + RW'(1);
                end else begin
                    col_c_r <= col_c_r + CW'(1);
                end
            end
            if (win_acc_s) begin
                win_c_r <= (win_c_r == WIN_LAST) ? '0 : win_c_r + WW'(1);
            end
        end
    end

    // A result exists once COLS pixels have passed through the row; the index
    // is the window offset of the oldest pixel and holds between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_r <= 1'b0;
            result_idx_r   <= '0;
        end else if (bus.abort) begin
            result_valid_r <= 1'b0;
        end else if (win_acc_s && (win_c_r >= WIN_FIRST_RES)) begin
            result_valid_r <= 1'b1;
            result_idx_r   <= win_c_r - WIN_FIRST_RES;
        end else begin
            result_valid_r <= 1'b0;
        end
    end

    assign bus.result_valid = result_valid_r;
    assign bus.result_idx   = result_idx_r;

endmodule

// File: tb/tb_ncc_seq_ctrl.sv
// Scoreboard bench for ncc_seq_ctrl: stimulus pushes cycle-stamped expected
// events derived from the descriptor/window rules; a negedge monitor pops them.
module tb_ncc_seq_ctrl;
    localparam int ROWS         = 16;
    localparam int COLS         = 16;
    localparam int PIX_PER_WORD = 4;
    localparam int WIN_PIXELS   = 640;
    localparam int NGRP         = COLS / PIX_PER_WORD;
    localparam int WORDS        = ROWS * NGRP;
    localparam int NRES         = WIN_PIXELS - COLS + 1;

    typedef struct { int cyc; int val; } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   nwin;
    int   nres;
    ev_t  exp_desc[$];
    ev_t  exp_res[$];
    int   exp_done[$];
    ev_t  e;

    ncc_seq_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .PIX_PER_WORD(PIX_PER_WORD),
                      .WIN_PIXELS(WIN_PIXELS)) bus ();

    ncc_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .PIX_PER_WORD(PIX_PER_WORD),
                   .WIN_PIXELS(WIN_PIXELS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic missing(input string name, input int due);
        vectors++;
        miscompares++;
        $display("FAIL %s: expected at cycle %0d, not seen by cycle %0d", name, due, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] idle_outs();
        return {37'd0, bus.desc_ready, bus.desc_load, bus.desc_row_sel, bus.desc_col_grp,
                bus.win_ready, bus.load_win_reg, bus.load_acc_sum_reg,
                bus.result_valid, bus.done};
    endfunction

    // Monitor: retire overdue expectations, then match every presented event.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_desc.size() > 0 && exp_desc[0].cyc < cyc) begin
                missing("desc_load_missing", exp_desc[0].cyc);
                void'(exp_desc.pop_front());
            end
            while (exp_res.size() > 0 && exp_res[0].cyc < cyc) begin
                missing("result_missing", exp_res[0].cyc);
                void'(exp_res.pop_front());
            end
            while (exp_done.size() > 0 && exp_done[0] < cyc) begin
                missing("done_missing", exp_done[0]);
                void'(exp_done.pop_front());
            end
            if (bus.desc_load) begin
                if (exp_desc.size() == 0) begin
                    chk("desc_load_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_desc.pop_front();
                    chk("desc_load_cycle", 64'(cyc), 64'(e.cyc));
                    chk("desc_row_sel", 64'(bus.desc_row_sel), 64'd1 << (e.val / NGRP));
                    chk("desc_col_grp", 64'(bus.desc_col_grp), 64'd1 << (e.val % NGRP));
                end
                if (!bus.desc_valid) chk("desc_load_without_valid", 64'd1, 64'd0);
            end
            if (bus.result_valid) begin
                nres++;
                if (exp_res.size() == 0) begin
                    chk("result_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_res.pop_front();
                    chk("result_cycle", 64'(cyc), 64'(e.cyc));
                    chk("result_idx", 64'(bus.result_idx), 64'(e.val));
                end
            end
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
                    chk("done_result_valid", 64'(bus.result_valid), 64'd1);
                    chk("done_result_idx", 64'(bus.result_idx), 64'(WIN_PIXELS - COLS));
                end
            end
            if (bus.load_win_reg || bus.load_acc_sum_reg) begin
                nwin++;
                chk("load_pair", 64'(bus.load_acc_sum_reg), 64'(bus.load_win_reg));
                chk("load_with_win_valid", 64'(bus.win_valid), 64'd1);
            end
            if (!bus.busy) begin
                chk("idle_outputs", idle_outs(), 64'd0);
            end
        end
    end

    // One match: dmode 0 continuous/1 toggling/2 random descriptor valid;
    // wmode 0 continuous (with a start pulse while busy)/1 3-cycle gap/2 random.
    task automatic run_match(input int dmode, input int wmode,
                             input int abort_after, input int rst_at);
        int  k;
        int  p;
        int  gap;
        bit  v;
        bit  t;
        nwin = 0;
        nres = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        k = 0;
        t = 1'b0;
        while (k < WORDS) begin
            if (abort_after >= 0 && k == abort_after) begin
                bus.abort      = 1'b1;
                bus.desc_valid = 1'b1;
                step();
                bus.abort      = 1'b0;
                bus.desc_valid = 1'b0;
                chk("abort_to_idle", 64'(bus.busy), 64'd0);
                chk("abort_desc_consumed", 64'(exp_desc.size()), 64'd0);
                exp_desc.delete();
                return;
            end
            case (dmode)
                0:       v = 1'b1;
                1:       begin t = ~t; v = t; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.desc_valid = v;
            if (v) begin
                exp_desc.push_back('{cyc, k});
                k++;
            end
            step();
        end
        bus.desc_valid = 1'b0;
        chk("win_stream_entered", 64'(bus.win_ready), 64'd1);
        chk("desc_ready_after_desc", 64'(bus.desc_ready), 64'd0);
        p   = 0;
        gap = 0;
        while (p < WIN_PIXELS) begin
            if (rst_at >= 0 && p == rst_at) begin
                bus.win_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("async_rst_outputs", idle_outs(), 64'd0);
                chk("async_rst_busy", 64'(bus.busy), 64'd0);
                chk("async_rst_idx", 64'(bus.result_idx), 64'd0);
                exp_res.delete();
                exp_done.delete();
                bus.start = 1'b1;
                step();
                chk("start_in_reset_busy", 64'(bus.busy), 64'd0);
                bus.start = 1'b0;
                rst = 1'b0;
                step();
                chk("idle_after_rst", 64'(bus.busy), 64'd0);
                return;
            end
            case (wmode)
                0:       v = 1'b1;
                1:       begin
                             v = !(p == 200 && gap < 3);
                             if (!v) gap++;
                         end
                default: v = ($urandom_range(0, 4) != 0);
            endcase
            bus.start     = (wmode == 0 && p == 100);
            bus.win_valid = v;
            if (v) begin
                if (p >= COLS - 1) exp_res.push_back('{cyc + 1, p - (COLS - 1)});
                if (p == WIN_PIXELS - 1) exp_done.push_back(cyc + 1);
                p++;
            end
            step();
        end
        bus.win_valid = 1'b0;
        bus.start     = 1'b0;
        chk("busy_in_done", 64'(bus.busy), 64'd1);
        step();
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("win_load_count", 64'(nwin), 64'(WIN_PIXELS));
        chk("result_count", 64'(nres), 64'(NRES));
        chk("queues_drained", 64'(exp_desc.size() + exp_res.size() + exp_done.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        nwin           = 0;
        nres           = 0;
        cyc            = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.desc_valid = 1'b0;
        bus.win_valid  = 1'b0;
        repeat (2) step();
        chk("reset_outputs", idle_outs(), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_idx", 64'(bus.result_idx), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        run_match(0, 0, -1, -1);
        run_match(1, 1, -1, -1);
        run_match(0, 0, 30, -1);
        run_match(2, 2, -1, -1);
        run_match(0, 0, -1, 300);
        run_match(2, 2, -1, -1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ncc_seq_ctrl.md
Name: ncc_seq_ctrl

Overview:
- Sequencer for the 16x16 NCC processing-element array.
- Accepts one 2048-bit descriptor as 64 32-bit words (4 pixels per word) over a valid/ready handshake and generates the one-hot row / column-group descriptor-load strobes.
- Then streams WIN_PIXELS window pixels into the array, driving the window-shift and accumulator-load enables.
- Flags each cycle on which the array's row accumulators hold a valid correlation result.

Parameters:
- ROWS, 16, PE rows in the array.
- COLS, 16, PEs per row.
- PIX_PER_WORD, 4, descriptor pixels per input word; COLS must be divisible by it.
- WIN_PIXELS, 640, window pixels streamed per match (must be >= COLS).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a match; ignored unless state is IDLE
- abort  in  1  synchronous abort; return to IDLE
- desc_valid  in  1  descriptor word present upstream
- desc_ready  out  1  controller accepts descriptor word
- desc_load  out  1  write strobe: loads the current word into the addressed PE group
- desc_row_sel  out  ROWS  one-hot row select
- desc_col_grp  out  COLS/PIX_PER_WORD  one-hot column-group select
- win_valid  in  1  window pixel present upstream
- win_ready  out  1  controller accepts window pixel
- load_win_reg  out  1  shift window registers
- load_acc_sum_reg  out  1  capture accumulator sums
- result_valid  out  1  array outputs hold a valid result
- result_idx  out  $clog2(WIN_PIXELS)  window offset of the valid result
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at match completion

Behaviour:
- States: IDLE, DESC_LOAD, WIN_STREAM, DONE. Reset and abort both force IDLE.
- Reset values: state IDLE; all counters 0; every output 0.
  - desc_row_sel and desc_col_grp are 0 in reset. Outside DESC_LOAD they are also forced to 0.
- Counters:
  - col_c: $clog2(COLS/PIX_PER_WORD) bits.
  - row_c: $clog2(ROWS) bits.
  - win_c: $clog2(WIN_PIXELS) bits.
- IDLE:
  - All handshake outputs are 0.
  - start=1 -> DESC_LOAD. col_c, row_c and win_c clear in the same edge.
- DESC_LOAD:
  - desc_ready=1 combinationally.
  - Word accepted (desc_valid & desc_ready):
    - desc_load=1 in the same cycle.
    - desc_row_sel = onehot(row_c), desc_col_grp = onehot(col_c), both combinational from the counters.
    - col_c increments. On wrap (col_c = last group) col_c returns to 0 and row_c increments.
  - Acceptance of the word at row_c=ROWS-1 and last col_c -> WIN_STREAM next cycle (64 words for the defaults).
  - desc_valid=0 stalls with no counter change.
- WIN_STREAM:
  - win_ready=1.
  - Pixel accepted (win_valid & win_ready):
    - load_win_reg=1 and load_acc_sum_reg=1 in the same cycle.
    - win_c increments.
  - No accept -> both load enables are 0; the array holds.
  - Acceptance with win_c = WIN_PIXELS-1 -> DONE next cycle.
- Result timing:
  - result_valid is registered. It is 1 in the cycle after an accepted pixel whose pre-increment win_c >= COLS-1, else 0.
  - result_idx = that win_c - (COLS-1), registered with result_valid. It holds its value while result_valid=0.
  - Exactly WIN_PIXELS-COLS+1 results are produced per match (625 for the defaults).
- DONE:
  - done=1 for one cycle. The final result_valid (idx 624 for the defaults) is asserted in this same cycle.
  - -> IDLE next cycle. start is ignored during DONE.
- Priority: abort > state logic.
  - abort in any non-IDLE state -> IDLE next cycle. No done, counters clear.
  - abort suppresses desc_load, load_win_reg and load_acc_sum_reg in its own cycle, and no handshake completes.
  - The result_valid pipeline register clears.
- Asynchronous rst mid-operation: immediate return to reset values; no partial done or result.
- start while busy: ignored; no restart.
- busy = (state != IDLE), combinational.

Test Plan:
1. Reset, start, 64 back-to-back descriptor words. Required:
   - desc_load pulses 64 times.
   - Word 0 -> row_sel=0x0001, col_grp=0x1; word 5 -> row_sel=0x0002, col_grp=0x2; word 63 -> row_sel=0x8000, col_grp=0x8.
   - WIN_STREAM entered the cycle after word 63.
2. Descriptor with desc_valid toggling every other cycle. Required: desc_load only on valid cycles; same 64-word select sequence as scenario 1; no skipped or duplicated selects.
3. 640 continuous window pixels. Required:
   - load_win_reg is high 640 cycles.
   - First result_valid is 1 cycle after the 16th accept, with idx=0.
   - Last result is idx=624, coincident with done.
   - 625 results in total; busy=0 the cycle after done.
4. Window stream with win_valid low for 3 cycles mid-stream. Required: load enables and result_valid are 0 during the gap; result_idx continues without a gap in numbering.
5. abort asserted after 30 descriptor words, then start again. Required:
   - IDLE next cycle; no done.
   - The new run's first desc_load has row_sel=0x0001, col_grp=0x1.
6. Async rst during WIN_STREAM at win_c=300. Required: all outputs are 0 immediately, busy=0; start is ignored while busy; start after reset is accepted.
